// File: rtl/add_sub_seg_serial.sv
// Segmented serial adder/subtractor: one SEG_WIDTH-bit slice per clock, with the
// carry passed between slices in a register. Valid/ready handshake on both sides.
module add_sub_seg_serial #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             overflow,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG_WIDTH;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_SEG = IDXW'(NSEG - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic                 carry;
  logic [IDXW-1:0]      seg;

  logic [31:0]          base;
  logic [SEG_WIDTH-1:0] seg_a;
  logic [SEG_WIDTH-1:0] seg_b;
  logic [SEG_WIDTH:0]   seg_sum;
  logic [WIDTH-1:0]     next_sum;
  logic                 last;

  // Current segment slice add and the sum register with that slice merged in
  always_comb begin
    base     = 32'(seg) * 32'(SEG_WIDTH);
    seg_a    = SEG_WIDTH'(a_reg >> base);
    seg_b    = SEG_WIDTH'(b_reg >> base);
    seg_sum  = {1'b0, seg_a} + {1'b0, seg_b} + (SEG_WIDTH + 1)'(carry);
    next_sum = sum;
    next_sum[base +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
    last     = (seg == LAST_SEG);
  end

  // Control FSM with registered handshake outputs and result registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      seg       <= '0;
      sum       <= '0;
      co        <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= X;
            b_reg    <= sub ? ~Y : Y;
            carry    <= sub ? 1'b1 : ci;
            seg      <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          sum   <= next_sum;
          carry <= seg_sum[SEG_WIDTH];
          if (last) begin
            // Top slice MSB is the result MSB, so overflow comes from this slice alone
            co        <= seg_sum[SEG_WIDTH];
            overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (seg_sum[SEG_WIDTH-1] != a_reg[WIDTH-1]);
            zero      <= (next_sum == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            seg <= seg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_seg_serial.sv
// Bench for add_sub_seg_serial across several WIDTH/SEG_WIDTH configurations.
module tb_add_sub_seg_serial;

  logic        clk;
  logic        rstb;
  logic [31:0] x_d;
  logic [31:0] y_d;
  logic        ci_d;
  logic        sub_d;
  logic [4:0]  iv;
  logic [4:0]  ordy;

  wire  [4:0]  ir;
  wire  [4:0]  ov;
  wire  [4:0]  cov;
  wire  [4:0]  ofv;
  wire  [4:0]  zv;
  wire  [7:0]  s0;
  wire  [31:0] s1;
  wire  [15:0] s2;
  wire  [15:0] s3;
  wire  [15:0] s4;
  logic [31:0] sum_a [5];

  int total;
  int bad;

  int w_of    [5] = '{8, 32, 16, 16, 16};
  int nseg_of [5] = '{4, 4, 16, 4, 1};

  assign sum_a[0] = {24'b0, s0};
  assign sum_a[1] = s1;
  assign sum_a[2] = {16'b0, s2};
  assign sum_a[3] = {16'b0, s3};
  assign sum_a[4] = {16'b0, s4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  add_sub_seg_serial #(.WIDTH(8), .SEG_WIDTH(2)) u0 (
    .clk(clk), .rstb(rstb), .in_valid(iv[0]), .in_ready(ir[0]),
    .X(x_d[7:0]), .Y(y_d[7:0]), .ci(ci_d), .sub(sub_d),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0),
    .co(cov[0]), .overflow(ofv[0]), .zero(zv[0]));

  add_sub_seg_serial #(.WIDTH(32), .SEG_WIDTH(8)) u1 (
    .clk(clk), .rstb(rstb), .in_valid(iv[1]), .in_ready(ir[1]),
    .X(x_d), .Y(y_d), .ci(ci_d), .sub(sub_d),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1),
    .co(cov[1]), .overflow(ofv[1]), .zero(zv[1]));

  add_sub_seg_serial #(.WIDTH(16), .SEG_WIDTH(1)) u2 (
    .clk(clk), .rstb(rstb), .in_valid(iv[2]), .in_ready(ir[2]),
    .X(x_d[15:0]), .Y(y_d[15:0]), .ci(ci_d), .sub(sub_d),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2),
    .co(cov[2]), .overflow(ofv[2]), .zero(zv[2]));

  add_sub_seg_serial #(.WIDTH(16), .SEG_WIDTH(4)) u3 (
    .clk(clk), .rstb(rstb), .in_valid(iv[3]), .in_ready(ir[3]),
    .X(x_d[15:0]), .Y(y_d[15:0]), .ci(ci_d), .sub(sub_d),
    .out_valid(ov[3]), .out_ready(ordy[3]), .sum(s3),
    .co(cov[3]), .overflow(ofv[3]), .zero(zv[3]));

  add_sub_seg_serial #(.WIDTH(16), .SEG_WIDTH(16)) u4 (
    .clk(clk), .rstb(rstb), .in_valid(iv[4]), .in_ready(ir[4]),
    .X(x_d[15:0]), .Y(y_d[15:0]), .ci(ci_d), .sub(sub_d),
    .out_valid(ov[4]), .out_ready(ordy[4]), .sum(s4),
    .co(cov[4]), .overflow(ofv[4]), .zero(zv[4]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: unsigned result/carry and signed range check on integers
  function automatic void model(input int w, input logic [31:0] xx, input logic [31:0] yy,
                                input logic c, input logic s,
                                output logic [31:0] rs, output logic rc,
                                output logic ro, output logic rz);
    longint m, half, ux, uy, sx, sy, r, sr;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ux   = longint'(xx) & m;
    uy   = longint'(yy) & m;
    sx   = (ux >= half) ? ux - (m + 1) : ux;
    sy   = (uy >= half) ? uy - (m + 1) : uy;
    if (s) begin
      r  = ux - uy;
      rc = (ux >= uy);
      sr = sx - sy;
    end else begin
      r  = ux + uy + longint'(c);
      rc = (r > m);
      sr = sx + sy + longint'(c);
    end
    ro = (sr > half - 1) || (sr < -half);
    rs = 32'(r & m);
    rz = ((r & m) == 0);
  endfunction

  task automatic do_op(input int k, input logic [31:0] xx, input logic [31:0] yy,
                       input logic c, input logic s, input int stall);
    logic [31:0] es;
    logic        ec, eo, ez;
    int          n;
    int          lat;
    n = nseg_of[k];
    model(w_of[k], xx, yy, c, s, es, ec, eo, ez);
    @(negedge clk);
    chk("idle_in_ready", 64'(ir[k]), 64'd1);
    x_d = xx; y_d = yy; ci_d = c; sub_d = s; iv[k] = 1'b1;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    x_d = $urandom; y_d = $urandom; ci_d = 1'($urandom); sub_d = 1'($urandom);
    chk("busy_in_ready", 64'(ir[k]), 64'd0);
    lat = 0;
    while (!ov[k] && lat < n + 4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(n));
    chk("out_valid", 64'(ov[k]), 64'd1);
    chk("sum", 64'(sum_a[k]), 64'(es));
    chk("co", 64'(cov[k]), 64'(ec));
    chk("overflow", 64'(ofv[k]), 64'(eo));
    chk("zero", 64'(zv[k]), 64'(ez));
    chk("done_in_ready", 64'(ir[k]), 64'd0);
    for (int i = 0; i < stall; i++) begin
      if (i == 3) begin
        x_d = 32'h0000_0055; y_d = 32'h0000_0033; iv[k] = 1'b1;
      end
      @(posedge clk);
      #1;
      iv[k] = 1'b0;
      chk("stall_valid", 64'(ov[k]), 64'd1);
      chk("stall_sum", 64'(sum_a[k]), 64'(es));
      chk("stall_flags", 64'({cov[k], ofv[k], zv[k]}), 64'({ec, eo, ez}));
      chk("stall_in_ready", 64'(ir[k]), 64'd0);
    end
    @(negedge clk);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    chk("post_valid", 64'(ov[k]), 64'd0);
    chk("post_in_ready", 64'(ir[k]), 64'd1);
    chk("post_hold_sum", 64'(sum_a[k]), 64'(es));
  endtask

  initial begin
    total = 0; bad = 0;
    rstb = 1'b0; iv = '0; ordy = '0;
    x_d = '0; y_d = '0; ci_d = 1'b0; sub_d = 1'b0;
    #12;
    for (int k = 0; k < 5; k++) begin
      chk("rst_in_ready", 64'(ir[k]), 64'd1);
      chk("rst_out_valid", 64'(ov[k]), 64'd0);
      chk("rst_sum", 64'(sum_a[k]), 64'd0);
      chk("rst_flags", 64'({cov[k], ofv[k], zv[k]}), 64'd0);
    end
    @(negedge clk);
    rstb = 1'b1;

    // 8-bit, 2-bit segments
    do_op(0, 32'h0F, 32'h01, 1'b0, 1'b0, 0);
    do_op(0, 32'h7F, 32'h01, 1'b0, 1'b0, 0);
    do_op(0, 32'hFF, 32'h01, 1'b0, 1'b0, 0);
    do_op(0, 32'hA5, 32'h3C, 1'b1, 1'b0, 0);
    do_op(0, 32'h10, 32'h10, 1'b0, 1'b1, 0);

    // 32-bit, 8-bit segments: subtract cases, then backpressure and a follow-up op
    do_op(1, 32'd5, 32'd7, 1'b0, 1'b1, 0);
    do_op(1, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 10);
    do_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 0);
    do_op(1, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 0);

    // Reset while in segment 2 of an operation
    @(negedge clk);
    x_d = 32'h1111_1111; y_d = 32'h2222_2222; ci_d = 1'b0; sub_d = 1'b0; iv[1] = 1'b1;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rstb = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov[1]), 64'd0);
    chk("midrst_in_ready", 64'(ir[1]), 64'd1);
    chk("midrst_sum", 64'(sum_a[1]), 64'd0);
    chk("midrst_flags", 64'({cov[1], ofv[1], zv[1]}), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    do_op(1, 32'd1, 32'd2, 1'b0, 1'b0, 0);

    // Random sweep on the 16-bit configurations
    for (int k = 2; k < 5; k++) begin
      for (int i = 0; i < 1000; i++) begin
        do_op(k, $urandom, $urandom, 1'($urandom), 1'($urandom), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_sub_seg_serial.md
Name: add_sub_seg_serial

Overview:
- Parametrised multi-cycle adder/subtractor: successor to the fixed 8-bit 2-bit-segment ripple-carry adder.
- Processes one SEG_WIDTH-bit segment per clock and carries between segments in a register, so a wide add costs NSEG cycles instead of a long combinational carry chain.
- Adds subtract mode, signed overflow, unsigned carry-out, zero flag, and valid/ready handshakes on input and output.
- Sits between operand registers and the ALU result mux.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SEG_WIDTH, 8, bits processed per cycle. Must divide WIDTH exactly, with 1 <= SEG_WIDTH <= WIDTH. NSEG = WIDTH/SEG_WIDTH.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rstb  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept operands.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- ci  in  1  carry-in; used only when sub=0.
- sub  in  1  1 = compute X-Y; 0 = compute X+Y+ci.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- co  out  1  unsigned carry-out. For subtract, co=1 means no borrow.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (rstb=0, asynchronous) forces:
  - state = IDLE
  - in_ready = 1, out_valid = 0
  - sum, co, overflow, zero, segment index and carry register = 0
  - A reset in CALC or DONE aborts the operation; no partial result is ever presented.
- State IDLE:
  - in_ready = 1.
  - On the edge where in_valid & in_ready:
    - latch A = X
    - latch Beff = sub ? ~Y : Y
    - carry = sub ? 1 : ci
    - seg = 0, clear the sum register
    - go to CALC
- State CALC:
  - in_ready = 0, out_valid = 0.
  - Each cycle: {c, s} = A[seg] + Beff[seg] + carry, as a (SEG_WIDTH+1)-bit sum.
  - Write s into sum[seg*SEG_WIDTH +: SEG_WIDTH]; carry <= c; seg <= seg+1.
  - On the final segment (seg == NSEG-1):
    - co <= c
    - overflow <= (A[MSB] == Beff[MSB]) && (s[MSB] != A[MSB])
    - zero <= (full assembled sum == 0)
    - go to DONE.
- State DONE:
  - out_valid = 1, in_ready = 0.
  - sum, co, overflow and zero hold stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: go to IDLE, out_valid deasserts the next cycle. Output registers keep their last values.
- Latency: out_valid rises exactly NSEG clocks after the accept edge. Throughput is one operation per NSEG+2 cycles at best.
- No overlap: in_ready is 0 in DONE, so a new operand is accepted no earlier than the cycle after the output handshake.
- Operand stability: X, Y, ci and sub may change freely after acceptance; only the latched copies are used.
- NSEG=1 degenerate case: CALC lasts one cycle. SEG_WIDTH=WIDTH is therefore a registered single-cycle adder.
- The segment index counter is ceil(log2(NSEG)) bits, minimum 1. No wrap past NSEG-1.
- in_valid while busy is ignored, not queued.

Test Plan:
- WIDTH=8, SEG=2:
  - X=0x0F, Y=0x01, ci=0, sub=0 -> sum=0x10, co=0, overflow=0, zero=0. out_valid 4 cycles after accept.
  - X=0x7F, Y=0x01, add -> sum=0x80, overflow=1, co=0.
  - X=0xFF, Y=0x01, add -> sum=0x00, co=1, zero=1, overflow=0.
- WIDTH=32, SEG=8, subtract:
  - X=5, Y=7 -> sum=0xFFFFFFFE, co=0 (borrow), overflow=0.
  - X=0x80000000, Y=1 -> sum=0x7FFFFFFF, overflow=1, co=1.
- Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, and the in_valid pulse during the stall is ignored. Raise out_ready -> IDLE next cycle; the next operand completes normally.
- Reset mid-CALC: assert rstb=0 at segment 2 -> out_valid=0 and all outputs 0 immediately. After release, a fresh op X=1, Y=2 gives sum=3.
- Random sweep, WIDTH=16, SEG in {1,4,16}: 1000 random X, Y, sub, ci vs reference model -> all four results match; latency always NSEG.
